// File: rtl/hpdcache_sram_wbuf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbuf_pkg
// Description : Shared types and byte-merge helper for the SRAM write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package hpdcache_sram_wbuf_pkg;

    localparam int unsigned c_ADDR_SIZE  = 6;
    localparam int unsigned c_DATA_SIZE  = 64;
    localparam int unsigned c_NDATA      = 1;
    localparam int unsigned c_WBUF_DEPTH = 2;
    localparam int unsigned c_DATA_W     = c_NDATA * c_DATA_SIZE;
    localparam int unsigned c_BE_W       = c_DATA_W / 8;

    typedef logic [c_ADDR_SIZE-1:0] wbuf_addr_t;
    typedef logic [c_DATA_W-1:0]    wbuf_data_t;
    typedef logic [c_BE_W-1:0]      wbuf_be_t;

    typedef struct packed {
        wbuf_addr_t addr;
        wbuf_data_t data;
        wbuf_be_t   be;
    } wbuf_entry_t;

    // Bytes whose enable is set come from new_data, all others from old_data.
    function automatic wbuf_data_t wbuf_merge(input wbuf_data_t old_data,
                                              input wbuf_data_t new_data,
                                              input wbuf_be_t   be);
        wbuf_data_t r;
        for (int i = 0; i < int'(c_BE_W); i++) begin
            r[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_sram_wbuf_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbuf_arb_if
// Description : Read/write request and SRAM macro bundle of the write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hpdcache_sram_wbuf_arb_if #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1
);
    logic                            rd_valid_i;
    logic                            rd_ready_o;
    logic [ADDR_SIZE-1:0]            rd_addr_i;
    logic                            rd_data_valid_o;
    logic [NDATA*DATA_SIZE-1:0]      rd_data_o;
    logic                            wr_valid_i;
    logic                            wr_ready_o;
    logic [ADDR_SIZE-1:0]            wr_addr_i;
    logic [NDATA*DATA_SIZE-1:0]      wr_data_i;
    logic [NDATA*DATA_SIZE/8-1:0]    wr_be_i;
    logic                            sram_cs_o;
    logic                            sram_we_o;
    logic [ADDR_SIZE-1:0]            sram_addr_o;
    logic [NDATA*DATA_SIZE-1:0]      sram_wdata_o;
    logic [NDATA*DATA_SIZE/8-1:0]    sram_wbe_o;
    logic [NDATA*DATA_SIZE-1:0]      sram_rdata_i;
    logic                            wbuf_empty_o;

    modport master (
        output rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, sram_rdata_i,
        input  rd_ready_o, rd_data_valid_o, rd_data_o, wr_ready_o, sram_cs_o, sram_we_o,
               sram_addr_o, sram_wdata_o, sram_wbe_o, wbuf_empty_o
    );

    modport slave (
        input  rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, sram_rdata_i,
        output rd_ready_o, rd_data_valid_o, rd_data_o, wr_ready_o, sram_cs_o, sram_we_o,
               sram_addr_o, sram_wdata_o, sram_wbe_o, wbuf_empty_o
    );
endinterface
`default_nettype wire

// File: rtl/hpdcache_sram_wbuf_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbuf_fifo
// Description : Coalescing circular write FIFO with address match lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_sram_wbuf_fifo
    import hpdcache_sram_wbuf_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = c_WBUF_DEPTH,
    parameter int unsigned CNT_W      = $clog2(WBUF_DEPTH + 1)
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        i_push,
    input  wbuf_entry_t      i_push_entry,
    input  wire logic        i_pop,
    input  wbuf_addr_t       i_rd_addr,
    output wbuf_entry_t      o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_hit,
    output wbuf_data_t       o_fwd_data,
    output wbuf_be_t         o_fwd_be
);
    localparam int unsigned c_PTR_W = $clog2(WBUF_DEPTH);

    wbuf_entry_t             r_entry [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0]      r_head;
    logic [c_PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]        r_count;
    logic [WBUF_DEPTH-1:0]   w_wr_match;
    logic [WBUF_DEPTH-1:0]   w_rd_match;
    logic                    w_alloc;

    // The head leaving this cycle cannot absorb a write; it would be lost.
    generate
        for (genvar gi = 0; gi < int'(WBUF_DEPTH); gi++) begin : g_match
            assign w_wr_match[gi] = r_valid[gi] && (r_entry[gi].addr == i_push_entry.addr) &&
                                    !(i_pop && (r_head == c_PTR_W'(gi)));
            assign w_rd_match[gi] = r_valid[gi] && (r_entry[gi].addr == i_rd_addr);
        end
    endgenerate

    assign o_hit   = |w_wr_match;
    assign w_alloc = i_push && !o_hit;
    assign o_head  = r_entry[r_head];
    assign o_count = r_count;

    always_comb begin
        o_fwd_data = '0;
        o_fwd_be   = '0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            if (w_rd_match[i]) begin
                o_fwd_data = r_entry[i].data;
                o_fwd_be   = r_entry[i].be;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Invalidate before allocating: when full, tail and head share a slot.
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_alloc, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            if (o_hit) begin
                for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                    if (w_wr_match[i]) begin
                        r_entry[i].data <= wbuf_merge(r_entry[i].data, i_push_entry.data, i_push_entry.be);
                        r_entry[i].be   <= r_entry[i].be | i_push_entry.be;
                    end
                end
            end else begin
                r_entry[r_tail] <= i_push_entry;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpdcache_sram_wbuf_arb.sv
`default_nettype none
// ============================================================================
// Module      : hpdcache_sram_wbuf_arb
// Description : Single-port SRAM arbiter: reads vs. coalescing write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_sram_wbuf_arb
    import hpdcache_sram_wbuf_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = c_WBUF_DEPTH
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    hpdcache_sram_wbuf_arb_if.slave   bus
);
    localparam int unsigned c_CNT_W = $clog2(WBUF_DEPTH + 1);

    logic [c_CNT_W-1:0] w_count;
    wbuf_entry_t        w_head;
    wbuf_entry_t        w_push_entry;
    wbuf_data_t         w_fwd_data;
    wbuf_be_t           w_fwd_be;
    logic               w_hit;
    logic               w_full;
    logic               w_drain;
    logic               w_rd_accept;
    logic               w_wr_accept;
    logic               r_rd_valid;
    wbuf_data_t         r_fwd_data;
    wbuf_be_t           r_fwd_be;

    assign w_push_entry = '{addr: bus.wr_addr_i, data: bus.wr_data_i, be: bus.wr_be_i};

    hpdcache_sram_wbuf_fifo #(
        .WBUF_DEPTH (WBUF_DEPTH),
        .CNT_W      (c_CNT_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_push       (w_wr_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (w_drain),
        .i_rd_addr    (bus.rd_addr_i),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_hit        (w_hit),
        .o_fwd_data   (w_fwd_data),
        .o_fwd_be     (w_fwd_be)
    );

    // A full buffer must drain first; otherwise reads win over draining.
    assign w_full      = (w_count == c_CNT_W'(WBUF_DEPTH));
    assign w_drain     = w_full || (!bus.rd_valid_i && (w_count != '0));
    assign w_rd_accept = bus.rd_valid_i && !w_full;
    assign w_wr_accept = bus.wr_valid_i && bus.wr_ready_o;

    assign bus.rd_ready_o   = !w_full;
    assign bus.wr_ready_o   = !w_full || w_hit || w_drain;
    assign bus.wbuf_empty_o = (w_count == '0);

    assign bus.sram_cs_o    = w_drain || w_rd_accept;
    assign bus.sram_we_o    = w_drain;
    assign bus.sram_addr_o  = w_drain ? w_head.addr : bus.rd_addr_i;
    assign bus.sram_wdata_o = w_head.data;
    assign bus.sram_wbe_o   = w_drain ? w_head.be : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_fwd_data <= w_fwd_data;
                r_fwd_be   <= w_fwd_be;
            end
        end
    end

    assign bus.rd_data_valid_o = r_rd_valid;
    assign bus.rd_data_o       = wbuf_merge(bus.sram_rdata_i, r_fwd_data, r_fwd_be);

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_sram_wbuf_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpdcache_sram_wbuf_arb
// Description : Directed + random bench with read scoreboard and SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdcache_sram_wbuf_arb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hpdcache_sram_wbuf_arb_if #(.ADDR_SIZE(6), .DATA_SIZE(64), .NDATA(1)) bus();

    hpdcache_sram_wbuf_arb #(.WBUF_DEPTH(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input logic [5:0] a);
        if (a == 6'd5) return 64'h0;
        if (a == 6'd9) return 64'hCCCC_CCCC_CCCC_CCCC;
        return {56'hA5A5_5A5A_0F0F_00, 2'b00, a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    // SRAM macro model: unwritten words read back their initial pattern
    logic [63:0] sram_mem [64];
    logic [63:0] sram_written;
    initial sram_written = '0;
    always @(posedge clk) begin
        if (bus.sram_cs_o) begin
            if (bus.sram_we_o) begin
                sram_mem[bus.sram_addr_o] <= merge(sram_written[bus.sram_addr_o] ? sram_mem[bus.sram_addr_o]
                                                   : init_val(bus.sram_addr_o), bus.sram_wdata_o, bus.sram_wbe_o);
                sram_written[bus.sram_addr_o] <= 1'b1;
            end else begin
                bus.sram_rdata_i <= sram_written[bus.sram_addr_o] ? sram_mem[bus.sram_addr_o]
                                                                  : init_val(bus.sram_addr_o);
            end
        end
    end

    logic [63:0] ref_mem [64];
    logic [63:0] exp_q [$];
    logic [63:0] last_rdata;
    logic        s_cs, s_we, s_rd_ready, s_wr_ready, s_empty, s_rdv;
    logic [5:0]  s_addr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wbe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp();
        if (bus.rd_data_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 64'(bus.rd_data_valid_o), 64'd0);
            end else begin
                last_rdata = bus.rd_data_o;
                chk("rd_data", bus.rd_data_o, exp_q.pop_front());
            end
        end
    endtask

    // One clock cycle: check last response, drive, sample combinational outputs, update the model
    task automatic step(input logic rv, input logic [5:0] ra, input logic wv, input logic [5:0] wa,
                        input logic [63:0] wd, input logic [7:0] wbe);
        @(negedge clk);
        s_rdv = bus.rd_data_valid_o;
        check_resp();
        bus.rd_valid_i = rv;
        bus.rd_addr_i  = ra;
        bus.wr_valid_i = wv;
        bus.wr_addr_i  = wa;
        bus.wr_data_i  = wd;
        bus.wr_be_i    = wbe;
        #1;
        s_cs = bus.sram_cs_o;       s_we = bus.sram_we_o;     s_addr = bus.sram_addr_o;
        s_wdata = bus.sram_wdata_o; s_wbe = bus.sram_wbe_o;   s_empty = bus.wbuf_empty_o;
        s_rd_ready = bus.rd_ready_o; s_wr_ready = bus.wr_ready_o;
        if (rv && s_rd_ready) exp_q.push_back(ref_mem[ra]);
        if (wv && s_wr_ready) ref_mem[wa] = merge(ref_mem[wa], wd, wbe);
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 1'b0, 6'd0, 64'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        last_rdata = '0;
        for (int a = 0; a < 64; a++) ref_mem[a] = init_val(6'(a));
        rst_n = 1'b0;
        bus.rd_valid_i = 1'b0; bus.rd_addr_i = '0;
        bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_be_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        idle();
        chk("rst_cs", 64'(s_cs), 64'd0);
        chk("rst_empty", 64'(s_empty), 64'd1);
        chk("rst_rdv", 64'(s_rdv), 64'd0);

        // Posted write then drain
        step(1'b0, 6'd0, 1'b1, 6'h3, 64'h8877_6655_4433_2211, 8'hFF);
        chk("w3_ready", 64'(s_wr_ready), 64'd1);
        chk("w3_cs_idle", 64'(s_cs), 64'd0);
        idle();
        chk("w3_drain_cs", 64'(s_cs), 64'd1);
        chk("w3_drain_we", 64'(s_we), 64'd1);
        chk("w3_drain_addr", 64'(s_addr), 64'h3);
        chk("w3_drain_wbe", 64'(s_wbe), 64'hFF);
        chk("w3_drain_wdata", s_wdata, 64'h8877_6655_4433_2211);
        chk("w3_not_empty", 64'(s_empty), 64'd0);
        idle();
        chk("w3_empty", 64'(s_empty), 64'd1);
        chk("w3_cs_after", 64'(s_cs), 64'd0);

        // Fill under continuous reads, then forced drain stalls the read
        step(1'b1, 6'h10, 1'b1, 6'h1, 64'h1111_1111_1111_1111, 8'hFF);
        chk("fill_rd_ready", 64'(s_rd_ready), 64'd1);
        chk("fill_we", 64'(s_we), 64'd0);
        step(1'b1, 6'h11, 1'b1, 6'h2, 64'h2222_2222_2222_2222, 8'hFF);
        chk("fill2_we", 64'(s_we), 64'd0);
        step(1'b1, 6'h12, 1'b0, 6'h0, 64'd0, 8'd0);
        chk("full_rd_stall", 64'(s_rd_ready), 64'd0);
        chk("full_drain_we", 64'(s_we), 64'd1);
        chk("full_drain_addr", 64'(s_addr), 64'h1);
        chk("full_wr_ready", 64'(s_wr_ready), 64'd1);
        step(1'b1, 6'h12, 1'b0, 6'h0, 64'd0, 8'd0);
        chk("after_full_rd_ready", 64'(s_rd_ready), 64'd1);
        idle();
        chk("drain2_addr", 64'(s_addr), 64'h2);
        idle();
        chk("fill_empty", 64'(s_empty), 64'd1);

        // Forwarding of a partial buffered write over SRAM contents
        step(1'b1, 6'h30, 1'b1, 6'h5, 64'h0000_0000_0000_007F, 8'h01);
        step(1'b1, 6'h5, 1'b0, 6'h0, 64'd0, 8'd0);
        idle();
        chk("fwd_rdata", last_rdata, 64'h0000_0000_0000_007F);
        idle();

        // Coalescing two halves while reads keep the entry from draining
        step(1'b1, 6'h20, 1'b1, 6'h5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        step(1'b1, 6'h21, 1'b1, 6'h5, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0);
        chk("coal_wr_ready", 64'(s_wr_ready), 64'd1);
        idle();
        chk("coal_drain_we", 64'(s_we), 64'd1);
        chk("coal_drain_addr", 64'(s_addr), 64'h5);
        chk("coal_drain_wbe", 64'(s_wbe), 64'hFF);
        chk("coal_drain_wdata", s_wdata, 64'hBBBB_BBBB_AAAA_AAAA);
        idle();
        chk("coal_single_write", 64'(s_cs), 64'd0);
        chk("coal_empty", 64'(s_empty), 64'd1);

        // Same-cycle read and write: read sees the old value
        step(1'b1, 6'h9, 1'b1, 6'h9, 64'h0123_4567_89AB_CDEF, 8'hFF);
        step(1'b1, 6'h9, 1'b0, 6'h0, 64'd0, 8'd0);
        chk("rw_same_old", last_rdata, 64'hCCCC_CCCC_CCCC_CCCC);
        idle();
        chk("rw_same_new", last_rdata, 64'h0123_4567_89AB_CDEF);

        // Random mix on a small address window
        for (int n = 0; n < 150; n++) begin
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom));
        end

        // Let everything drain, then compare final SRAM contents
        for (int n = 0; n < 20 && !(s_empty && exp_q.size() == 0 && !s_rdv); n++) idle();
        idle();
        chk("final_empty", 64'(s_empty), 64'd1);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        for (int a = 0; a < 64; a++) begin
            chk($sformatf("mem_%0d", a), sram_written[a] ? sram_mem[a] : init_val(6'(a)), ref_mem[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
